climate_ctrl_fsm: RTL



---
 rtl/climate_ctrl_fsm.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/climate_ctrl_fsm.sv
// Greenhouse climate controller: thermometer-coded sensors drive heater/cooler
// through a hysteresis FSM with minimum dwell and a latched sensor-fault state.
module climate_ctrl_fsm #(
  parameter int N_SENS       = 4,
  parameter int HEAT_ON      = 0,
  parameter int HEAT_OFF     = 2,
  parameter int COOL_ON      = 4,
  parameter int COOL_OFF     = 2,
  parameter int MIN_DWELL    = 3,
  parameter int FAULT_CYCLES = 4
) (
  input  logic                            clk_2,
  input  logic                            reset_n,
  input  logic [N_SENS-1:0]               temp_code,
  input  logic                            fault_clr,
  output logic                            heater,
  output logic                            cooler,
  output logic                            fault,
  output logic [$clog2(N_SENS+1)-1:0]     level,
  output logic [1:0]                      state
);

  localparam int LVL_W   = $clog2(N_SENS + 1);
  localparam int DWELL_W = (MIN_DWELL > 1) ? $clog2(MIN_DWELL) : 1;
  localparam int INV_W   = (FAULT_CYCLES > 1) ? $clog2(FAULT_CYCLES) : 1;

  localparam logic [LVL_W-1:0]   HEAT_ON_L  = LVL_W'(HEAT_ON);
  localparam logic [LVL_W-1:0]   HEAT_OFF_L = LVL_W'(HEAT_OFF);
  localparam logic [LVL_W-1:0]   COOL_ON_L  = LVL_W'(COOL_ON);
  localparam logic [LVL_W-1:0]   COOL_OFF_L = LVL_W'(COOL_OFF);
  localparam logic [DWELL_W-1:0] DWELL_MAX  = DWELL_W'(MIN_DWELL - 1);
  localparam logic [INV_W-1:0]   INV_MAX    = INV_W'(FAULT_CYCLES - 1);
  localparam logic [N_SENS-1:0]  CODE_ONE   = N_SENS'(1);

  if (!((HEAT_ON < HEAT_OFF) && (HEAT_OFF <= COOL_OFF) && (COOL_OFF < COOL_ON) &&
        (COOL_ON <= N_SENS) && (HEAT_ON >= 0) && (MIN_DWELL >= 1) && (FAULT_CYCLES >= 1)))
  begin : g_param_check
    $error("climate_ctrl_fsm: illegal parameter set");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HEAT  = 2'd1,
    COOL  = 2'd2,
    FAULT = 2'd3
  } state_t;

  function automatic logic [LVL_W-1:0] popcount(input logic [N_SENS-1:0] c);
    logic [LVL_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < N_SENS; i++) begin
      cnt = cnt + LVL_W'(c[i]);
    end
    return cnt;
  endfunction

  // Thermometer form: adding one to a run of low ones leaves no overlap.
  function automatic logic is_thermo(input logic [N_SENS-1:0] c);
    logic [N_SENS-1:0] inc;
    inc = c + CODE_ONE;
    return ((c & inc) == '0);
  endfunction

  state_t               state_r;
  state_t               state_nxt_s;
  logic [DWELL_W-1:0]   dwell_cnt_r;
  logic [DWELL_W-1:0]   dwell_nxt_s;
  logic [INV_W-1:0]     inv_cnt_r;
  logic [INV_W-1:0]     inv_nxt_s;
  logic [LVL_W-1:0]     level_r;
  logic [LVL_W-1:0]     pop_s;
  logic                 valid_s;
  logic                 dwell_ok_s;
  logic                 heater_r;
  logic                 cooler_r;
  logic                 fault_r;

  assign pop_s      = popcount(temp_code);
  assign valid_s    = is_thermo(temp_code);
  assign dwell_ok_s = (dwell_cnt_r == DWELL_MAX);

  // Next-state selection in priority order; sensor-fault escalation ignores dwell.
  always_comb begin
    state_nxt_s = state_r;
    if ((state_r != FAULT) && !valid_s) begin
      if (inv_cnt_r == INV_MAX) begin
        state_nxt_s = FAULT;
      end else begin
        state_nxt_s = state_r;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (dwell_ok_s && (pop_s <= HEAT_ON_L)) begin
            state_nxt_s = HEAT;
          end else if (dwell_ok_s && (pop_s >= COOL_ON_L)) begin
            state_nxt_s = COOL;
          end else begin
            state_nxt_s = IDLE;
          end
        end
        HEAT: begin
          if (dwell_ok_s && (pop_s >= HEAT_OFF_L)) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = HEAT;
          end
        end
        COOL: begin
          if (dwell_ok_s && (pop_s <= COOL_OFF_L)) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = COOL;
          end
        end
        FAULT: begin
          if (fault_clr && valid_s) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = FAULT;
          end
        end
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Dwell and invalid-run counters; a state change always restarts the dwell.
  always_comb begin
    dwell_nxt_s = dwell_cnt_r;
    inv_nxt_s   = inv_cnt_r;
    if (state_nxt_s != state_r) begin
      dwell_nxt_s = '0;
    end else if (dwell_ok_s) begin
      dwell_nxt_s = dwell_cnt_r;
    end else begin
      dwell_nxt_s = dwell_cnt_r + DWELL_W'(1);
    end
    if (valid_s || ((state_r == FAULT) && (state_nxt_s == IDLE))) begin
      inv_nxt_s = '0;
    end else if (inv_cnt_r == INV_MAX) begin
      inv_nxt_s = inv_cnt_r;
    end else begin
      inv_nxt_s = inv_cnt_r + INV_W'(1);
    end
  end

  // State, counters, level and decoded outputs all update on the same edge.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      dwell_cnt_r <= DWELL_MAX;
      inv_cnt_r   <= '0;
      level_r     <= '0;
      heater_r    <= 1'b0;
      cooler_r    <= 1'b0;
      fault_r     <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      dwell_cnt_r <= dwell_nxt_s;
      inv_cnt_r   <= inv_nxt_s;
      level_r     <= valid_s ? pop_s : level_r;
      heater_r    <= (state_nxt_s == HEAT);
      cooler_r    <= (state_nxt_s == COOL);
      fault_r     <= (state_nxt_s == FAULT);
    end
  end

  assign heater = heater_r;
  assign cooler = cooler_r;
  assign fault  = fault_r;
  assign level  = level_r;
  assign state  = state_r;

endmodule
